// File: rtl/bob_line_reader_if.sv
// Read port between the BOB line reader and the dual-clock line buffer.
// The reader drives bank/address; the buffer returns data one cycle later.
interface bob_line_reader_if;
  logic       rd_bank;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;

  modport master (output rd_bank, output rd_addr, input rd_data);
  modport slave  (input rd_bank, input rd_addr, output rd_data);
endinterface

// File: rtl/bob_line_reader.sv
// BOB deinterlace read side: streams each completed camera line twice,
// offsets bottom fields by one blank line, and delay-matches de/vs to pix_out.
module bob_line_reader #(
  parameter int         H_ACTIVE  = 720,
  parameter logic [7:0] BLANK_VAL = 8'h10
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              vs_in,
  input  logic              field_in,
  input  logic              line_done,
  input  logic              line_bank,
  bob_line_reader_if.master buf_if,
  output logic [7:0]        pix_out,
  output logic              de_out,
  output logic              vs_out,
  output logic              underrun
);

  localparam logic [9:0] X_MAX  = 10'(H_ACTIVE);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic       new_flag_reg, new_flag_next;
  logic       last_bank_reg, last_bank_next;
  logic       pair_phase_reg, pair_phase_next;
  logic       underrun_reg, underrun_next;
  logic       bottom_pending_reg, bottom_pending_next;
  logic       rd_bank_reg, rd_bank_next;
  logic       line_blank_reg, line_blank_next;
  logic [9:0] x_reg, x_next;
  logic       de_prev_reg, vs_prev_reg;

  logic       de_rise, vs_rise, new_flag_eff, blank_now;

  logic [9:0] rd_addr_reg;
  logic       de_pipe_reg [3];
  logic       vs_pipe_reg [3];
  logic       blank_d1_reg, blank_d2_reg;
  logic [7:0] pix_reg;

  assign de_rise      = de_in & ~de_prev_reg;
  assign vs_rise      = vs_in & ~vs_prev_reg;
  // A line_done coinciding with a line start is folded in before the decision.
  assign new_flag_eff = new_flag_reg | line_done;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      new_flag_reg       <= 1'b0;
      last_bank_reg      <= 1'b0;
      pair_phase_reg     <= 1'b0;
      underrun_reg       <= 1'b0;
      bottom_pending_reg <= 1'b0;
      rd_bank_reg        <= 1'b0;
      line_blank_reg     <= 1'b1;
      x_reg              <= '0;
      de_prev_reg        <= 1'b0;
      vs_prev_reg        <= 1'b0;
    end else begin
      state_reg          <= state_next;
      new_flag_reg       <= new_flag_next;
      last_bank_reg      <= last_bank_next;
      pair_phase_reg     <= pair_phase_next;
      underrun_reg       <= underrun_next;
      bottom_pending_reg <= bottom_pending_next;
      rd_bank_reg        <= rd_bank_next;
      line_blank_reg     <= line_blank_next;
      x_reg              <= x_next;
      de_prev_reg        <= de_in;
      vs_prev_reg        <= vs_in;
    end
  end

  always_comb begin
    state_next          = state_reg;
    new_flag_next       = new_flag_eff;
    last_bank_next      = line_done ? line_bank : last_bank_reg;
    pair_phase_next     = pair_phase_reg;
    underrun_next       = underrun_reg;
    bottom_pending_next = bottom_pending_reg;
    rd_bank_next        = rd_bank_reg;
    line_blank_next     = line_blank_reg;

    case (state_reg)
      IDLE:      state_next = IDLE;
      WAIT_LINE: if (line_done) state_next = RUN;
      RUN:       state_next = RUN;
      default:   state_next = IDLE;
    endcase

    if (de_rise) begin
      if (state_reg != RUN) begin
        line_blank_next = 1'b1;
      end else if (bottom_pending_reg) begin
        // Bottom-field offset line: blank, not a pair member, bank untouched.
        line_blank_next     = 1'b1;
        bottom_pending_next = 1'b0;
      end else begin
        line_blank_next = 1'b0;
        pair_phase_next = ~pair_phase_reg;
        if (!pair_phase_reg) begin
          if (new_flag_eff) begin
            rd_bank_next  = last_bank_next;
            new_flag_next = 1'b0;
          end else begin
            underrun_next = 1'b1;
          end
        end
      end
    end

    if (vs_rise) begin
      state_next          = WAIT_LINE;
      bottom_pending_next = field_in;
      pair_phase_next     = 1'b0;
      underrun_next       = 1'b0;
    end

    if (de_in) x_next = (x_reg == X_MAX) ? X_MAX : x_reg + 10'd1;
    else       x_next = '0;
  end

  // The line's blank decision is taken on the rising de cycle itself.
  assign blank_now = (de_rise ? line_blank_next : line_blank_reg) | (x_reg >= X_MAX);

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      rd_addr_reg    <= '0;
      de_pipe_reg[0] <= 1'b0;
      vs_pipe_reg[0] <= 1'b0;
      blank_d1_reg   <= 1'b0;
      blank_d2_reg   <= 1'b0;
      pix_reg        <= '0;
    end else begin
      if (de_in) rd_addr_reg <= (x_reg >= X_MAX) ? X_LAST : x_reg;
      de_pipe_reg[0] <= de_in;
      vs_pipe_reg[0] <= vs_in;
      blank_d1_reg   <= blank_now;
      blank_d2_reg   <= blank_d1_reg;
      // rd_data is valid in the stage where de_pipe_reg[1] is set.
      if (!de_pipe_reg[1])  pix_reg <= '0;
      else if (blank_d2_reg) pix_reg <= BLANK_VAL;
      else                   pix_reg <= buf_if.rd_data;
    end
  end

  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_sync_dly
      always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
          de_pipe_reg[gi] <= 1'b0;
          vs_pipe_reg[gi] <= 1'b0;
        end else begin
          de_pipe_reg[gi] <= de_pipe_reg[gi-1];
          vs_pipe_reg[gi] <= vs_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign buf_if.rd_bank = rd_bank_reg;
  assign buf_if.rd_addr = rd_addr_reg;
  assign pix_out        = pix_reg;
  assign de_out         = de_pipe_reg[2];
  assign vs_out         = vs_pipe_reg[2];
  assign underrun       = underrun_reg;

endmodule

// File: tb/tb_bob_line_reader.sv
// Directed bench for bob_line_reader: line doubling, bottom offset, underrun,
// same-cycle line_done, over-length de and asynchronous reset.
module tb_bob_line_reader;

  logic pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  logic       rst, de_in, vs_in, field_in, line_done, line_bank;
  logic [7:0] pix_out;
  logic       de_out, vs_out, underrun;

  bob_line_reader_if buf_if ();

  bob_line_reader #(.H_ACTIVE(720), .BLANK_VAL(8'h10)) dut (
    .pix_clk   (pix_clk),
    .rst       (rst),
    .de_in     (de_in),
    .vs_in     (vs_in),
    .field_in  (field_in),
    .line_done (line_done),
    .line_bank (line_bank),
    .buf_if    (buf_if),
    .pix_out   (pix_out),
    .de_out    (de_out),
    .vs_out    (vs_out),
    .underrun  (underrun)
  );

  // Line buffer stand-in: bank 0 holds addr[7:0], bank 1 holds its inverse.
  always @(posedge pix_clk)
    buf_if.rd_data <= buf_if.rd_bank ? ~buf_if.rd_addr[7:0] : buf_if.rd_addr[7:0];

  typedef struct {
    logic       de;
    logic       vs;
    logic [7:0] px;
  } exp_t;

  exp_t       hist[$];
  int         total = 0;
  int         bad = 0;
  int         px_err = 0;
  int         de_err = 0;
  logic [7:0] first_got, first_exp;

  function automatic logic [7:0] dat(input logic bank, input int j);
    logic [7:0] v;
    v = 8'(j);
    return bank ? ~v : v;
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hist_zero();
    exp_t e;
    e.de = 1'b0; e.vs = 1'b0; e.px = 8'h00;
    hist.delete();
    repeat (3) hist.push_back(e);
  endtask

  // One clock: compare outputs with what was driven three cycles earlier, then drive.
  task automatic step(input logic de, input logic vs, input logic ld, input logic lb,
                      input logic [7:0] px);
    exp_t e;
    @(negedge pix_clk);
    e = hist[hist.size()-3];
    if (de_out !== e.de || vs_out !== e.vs) de_err++;
    if (pix_out !== e.px) begin
      if (px_err == 0) begin first_got = pix_out; first_exp = e.px; end
      px_err++;
    end
    de_in = de; vs_in = vs; line_done = ld; line_bank = lb;
    e.de = de; e.vs = vs; e.px = de ? px : 8'h00;
    hist.push_back(e);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic check_stream(input string tag);
    total++;
    assert (px_err === 0) else begin
      bad++;
      $error("FAIL %s pixels: %0d wrong, first got=%h exp=%h", tag, px_err, first_got, first_exp);
    end
    total++;
    assert (de_err === 0) else begin
      bad++;
      $error("FAIL %s de/vs align: %0d wrong cycles, exp 0", tag, de_err);
    end
    px_err = 0;
    de_err = 0;
  endtask

  task automatic run_line(input int len, input logic ld, input logic lb,
                          input logic blank, input logic bank, input string tag);
    logic [7:0] px;
    for (int j = 0; j < len; j++) begin
      px = (blank || j >= 720) ? 8'h10 : dat(bank, j);
      step(1'b1, 1'b0, (j == 0) ? ld : 1'b0, lb, px);
      if (j == 3) chk({tag, " rd_bank"}, 10'(buf_if.rd_bank), 10'(bank));
      if (j == 5) chk({tag, " rd_addr"}, buf_if.rd_addr, 10'd4);
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_stream(tag);
    $display("line %s: len=%0d blank=%0d bank=%0d", tag, len, blank, bank);
  endtask

  task automatic pulse_ld(input logic lb);
    step(1'b0, 1'b0, 1'b1, lb, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync(input logic f);
    field_in = f;
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_stream(f ? "vsync bottom" : "vsync top");
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " pix_out"},  10'(pix_out), 10'd0);
    chk({tag, " de_out"},   10'(de_out), 10'd0);
    chk({tag, " vs_out"},   10'(vs_out), 10'd0);
    chk({tag, " underrun"}, 10'(underrun), 10'd0);
    chk({tag, " rd_bank"},  10'(buf_if.rd_bank), 10'd0);
    chk({tag, " rd_addr"},  buf_if.rd_addr, 10'd0);
  endtask

  initial begin
    rst = 1'b1; de_in = 1'b0; vs_in = 1'b0; field_in = 1'b0;
    line_done = 1'b0; line_bank = 1'b0;
    hist_zero();
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Before any vsync, then in WAIT_LINE: blank lines.
    run_line(20, 1'b0, 1'b0, 1'b1, 1'b0, "idle");
    vsync(1'b0);
    run_line(20, 1'b0, 1'b0, 1'b1, 1'b0, "wait");

    // Top field: one stored line shown twice, then a starved pair.
    pulse_ld(1'b0);
    run_line(720, 1'b0, 1'b0, 1'b0, 1'b0, "A");
    run_line(720, 1'b0, 1'b0, 1'b0, 1'b0, "B");
    chk("underrun after pair", 10'(underrun), 10'd0);
    run_line(720, 1'b0, 1'b0, 1'b0, 1'b0, "C starved");
    chk("underrun starved", 10'(underrun), 10'd1);
    run_line(720, 1'b0, 1'b0, 1'b0, 1'b0, "D");

    // Bottom field: one blank offset line, then the pair.
    vsync(1'b1);
    chk("underrun cleared by vs", 10'(underrun), 10'd0);
    pulse_ld(1'b0);
    run_line(720, 1'b0, 1'b0, 1'b1, 1'b0, "E offset");
    run_line(720, 1'b0, 1'b0, 1'b0, 1'b0, "F");
    run_line(720, 1'b0, 1'b0, 1'b0, 1'b0, "G");

    // line_done(bank1) coincides with the pair start.
    run_line(720, 1'b1, 1'b1, 1'b0, 1'b1, "H same-cycle");
    run_line(720, 1'b0, 1'b0, 1'b0, 1'b1, "I");
    chk("underrun before J", 10'(underrun), 10'd0);
    run_line(720, 1'b0, 1'b0, 1'b0, 1'b1, "J no new");
    chk("underrun new_flag consumed", 10'(underrun), 10'd1);

    // Over-length de.
    run_line(730, 1'b0, 1'b0, 1'b0, 1'b1, "K long");
    chk("rd_addr saturated", buf_if.rd_addr, 10'd719);

    // Reset asserted mid-line acts immediately.
    for (int j = 0; j < 100; j++) step(1'b1, 1'b0, 1'b0, 1'b0, dat(1'b1, j));
    #2 rst = 1'b1;
    #1 chk_outputs_zero("mid-line reset");
    hist_zero();
    px_err = 0;
    de_err = 0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    run_line(20, 1'b0, 1'b0, 1'b1, 1'b0, "post-rst idle");
    pulse_ld(1'b1);
    run_line(20, 1'b0, 1'b0, 1'b1, 1'b0, "post-rst ld no vs");
    vsync(1'b0);
    pulse_ld(1'b1);
    run_line(40, 1'b0, 1'b0, 1'b0, 1'b1, "post-rst run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
